// File: rtl/branch_ctrl_pkg.sv
// Shared widths, comparator op codes, decoder type codes and state encoding
// for the branch/jump resolution unit.
`timescale 1ns/1ps
package branch_ctrl_pkg;

  localparam int unsigned REG_LEN = 12;

  localparam logic [2:0] CMP_EQ   = 3'b000;
  localparam logic [2:0] CMP_NE   = 3'b001;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_GE   = 3'b011;
  localparam logic [2:0] CMP_LTU  = 3'b100;
  localparam logic [2:0] CMP_GEU  = 3'b101;
  localparam logic [2:0] CMP_NONE = 3'b111;

  typedef enum logic [1:0] {
    DT_BR   = 2'b00,
    DT_JAL  = 2'b01,
    DT_JALR = 2'b10,
    DT_RSV  = 2'b11
  } dec_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RESOLVE = 2'b01,
    ST_RESP    = 2'b10,
    ST_FLUSH   = 2'b11
  } state_e;

  typedef struct packed {
    dec_type_e          dtype;
    logic [2:0]         funct3;
    logic [REG_LEN-1:0] pc;
    logic [REG_LEN-1:0] imm;
    logic [REG_LEN-1:0] rs1;
  } ctl_req_t;

  // Branch funct3 to comparator op; CMP_NONE marks the two undefined encodings.
  function automatic logic [2:0] map_funct3(input logic [2:0] f3);
    logic [2:0] op;
    op = CMP_NONE;
    case (f3)
      3'b000:  op = CMP_EQ;
      3'b001:  op = CMP_NE;
      3'b100:  op = CMP_LT;
      3'b101:  op = CMP_GE;
      3'b110:  op = CMP_LTU;
      3'b111:  op = CMP_GEU;
      default: op = CMP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/branch_ctrl.sv
// Control-transfer resolution: captures a BR/JAL/JALR, drives the external
// comparator, then redirects fetch, writes the link register or raises an exception.
`timescale 1ns/1ps
import branch_ctrl_pkg::*;

module branch_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [1:0]         dec_type,
  input  logic [2:0]         funct3,
  input  logic [REG_LEN-1:0] pc_in,
  input  logic [REG_LEN-1:0] imm,
  input  logic [REG_LEN-1:0] rs1_base,
  input  logic               kill,
  output logic [2:0]         cmp_op,
  input  logic               cmp_b,
  output logic               redirect,
  output logic [REG_LEN-1:0] pc_next,
  output logic               link_we,
  output logic [REG_LEN-1:0] link_d,
  output logic               misalign,
  output logic               illegal,
  output logic [REG_LEN-1:0] taken_cnt
);

  state_e             state;
  ctl_req_t           req_q;
  logic               cmp_b_q;
  logic               flush_cnt;
  logic [2:0]         cmp_op_q;
  logic [REG_LEN-1:0] pc_next_q;
  logic [REG_LEN-1:0] taken_cnt_q;

  logic [REG_LEN-1:0] sum_pc;
  logic [REG_LEN-1:0] sum_jalr;
  logic [REG_LEN-1:0] target;
  logic [REG_LEN-1:0] link_val;
  logic               is_jump;
  logic               is_illegal;
  logic               taken;
  logic               resp_live;

  // Target and decision logic, evaluated from captured operands during RESP.
  assign sum_pc     = req_q.pc + req_q.imm;
  assign sum_jalr   = req_q.rs1 + req_q.imm;
  assign target     = (req_q.dtype == DT_JALR) ? {sum_jalr[REG_LEN-1:1], 1'b0} : sum_pc;
  assign link_val   = req_q.pc + REG_LEN'(4);
  assign is_jump    = (req_q.dtype == DT_JAL) || (req_q.dtype == DT_JALR);
  assign is_illegal = (req_q.dtype == DT_RSV) ||
                      ((req_q.dtype == DT_BR) && (map_funct3(req_q.funct3) == CMP_NONE));
  assign taken      = ((req_q.dtype == DT_BR) && cmp_b_q) || is_jump;

  // kill in RESP must suppress the pulses in that same cycle.
  assign resp_live  = (state == ST_RESP) && !kill;

  assign redirect   = resp_live && !is_illegal && taken && (target[1:0] == 2'b00);
  assign misalign   = resp_live && !is_illegal && taken && target[1];
  assign link_we    = resp_live && !is_illegal && is_jump && !target[1];
  assign illegal    = resp_live && is_illegal;
  assign link_d     = link_we ? link_val : '0;
  assign pc_next    = redirect ? target : pc_next_q;
  assign dec_ready  = (state == ST_IDLE);
  assign cmp_op     = cmp_op_q;
  assign taken_cnt  = taken_cnt_q;

  // State machine and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      cmp_b_q     <= 1'b0;
      flush_cnt   <= 1'b0;
      cmp_op_q    <= CMP_NONE;
      pc_next_q   <= '0;
      taken_cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dec_valid) begin
            req_q.dtype  <= dec_type_e'(dec_type);
            req_q.funct3 <= funct3;
            req_q.pc     <= pc_in;
            req_q.imm    <= imm;
            req_q.rs1    <= rs1_base;
            cmp_op_q     <= (dec_type == DT_BR) ? map_funct3(funct3) : CMP_NONE;
            state        <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          cmp_op_q <= CMP_NONE;
          cmp_b_q  <= cmp_b;
          state    <= kill ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          if (redirect) begin
            pc_next_q   <= target;
            taken_cnt_q <= taken_cnt_q + REG_LEN'(1);
            flush_cnt   <= 1'b0;
            state       <= ST_FLUSH;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (kill || flush_cnt) begin
            state <= ST_IDLE;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed scoreboard bench for branch_ctrl: expected RESP outcomes are queued
// at issue time and compared when the instruction reaches RESP.
`timescale 1ns/1ps
import branch_ctrl_pkg::*;

module tb_branch_ctrl;

  localparam int unsigned W = REG_LEN;

  logic         clk;
  logic         rst_n;
  logic         dec_valid;
  logic         dec_ready;
  logic [1:0]   dec_type;
  logic [2:0]   funct3;
  logic [W-1:0] pc_in;
  logic [W-1:0] imm;
  logic [W-1:0] rs1_base;
  logic         kill;
  logic [2:0]   cmp_op;
  logic         cmp_b;
  logic         redirect;
  logic [W-1:0] pc_next;
  logic         link_we;
  logic [W-1:0] link_d;
  logic         misalign;
  logic         illegal;
  logic [W-1:0] taken_cnt;

  branch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_type(dec_type), .funct3(funct3), .pc_in(pc_in), .imm(imm),
    .rs1_base(rs1_base), .kill(kill), .cmp_op(cmp_op), .cmp_b(cmp_b),
    .redirect(redirect), .pc_next(pc_next), .link_we(link_we), .link_d(link_d),
    .misalign(misalign), .illegal(illegal), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         redirect;
    logic         link_we;
    logic         misalign;
    logic         illegal;
    logic         ready_resp;
    logic         flush;
    logic [2:0]   cmp_op;
    logic [W-1:0] pcn;
    logic [W-1:0] link_d;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_cnt  = '0;
  logic [W-1:0] exp_pcn  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour built from the architectural description.
  function automatic exp_t model(input logic [1:0] t, input logic [2:0] f3,
                                 input logic [W-1:0] pc, input logic [W-1:0] im,
                                 input logic [W-1:0] rs1, input logic cb, input int kill_at);
    exp_t         e;
    logic         ill;
    logic         tk;
    logic [W-1:0] tgt;
    ill = (t == 2'b11) || (t == 2'b00 && (f3 == 3'b010 || f3 == 3'b011));
    case (f3)
      3'b000:  e.cmp_op = 3'b000;
      3'b001:  e.cmp_op = 3'b001;
      3'b100:  e.cmp_op = 3'b010;
      3'b101:  e.cmp_op = 3'b011;
      3'b110:  e.cmp_op = 3'b100;
      3'b111:  e.cmp_op = 3'b101;
      default: e.cmp_op = 3'b111;
    endcase
    if (t != 2'b00) e.cmp_op = 3'b111;
    if (t == 2'b10) begin
      tgt    = rs1 + im;
      tgt[0] = 1'b0;
    end else begin
      tgt = pc + im;
    end
    tk = (t == 2'b00 && cb) || t == 2'b01 || t == 2'b10;
    e.redirect = 1'b0; e.link_we = 1'b0; e.misalign = 1'b0; e.illegal = 1'b0;
    e.flush = 1'b0; e.link_d = '0; e.ready_resp = (kill_at == 1);
    if (kill_at == 1 || kill_at == 2) begin
      e.ready_resp = (kill_at == 1);
    end else if (ill) begin
      e.illegal = 1'b1;
    end else begin
      if (tk && tgt[1:0] == 2'b00) begin
        e.redirect = 1'b1;
        e.flush    = 1'b1;
        exp_pcn    = tgt;
        exp_cnt    = exp_cnt + W'(1);
      end
      e.misalign = tk && tgt[1];
      if ((t == 2'b01 || t == 2'b10) && !tgt[1]) begin
        e.link_we = 1'b1;
        e.link_d  = pc + W'(4);
      end
    end
    e.pcn = exp_pcn;
    e.cnt = exp_cnt;
    return e;
  endfunction

  // kill_at: 0 none, 1 RESOLVE, 2 RESP, 3 FLUSH, 4 reset during FLUSH.
  task automatic issue(input logic [1:0] t, input logic [2:0] f3, input logic [W-1:0] pc,
                       input logic [W-1:0] im, input logic [W-1:0] rs1, input logic cb,
                       input int kill_at, input bit junk);
    exp_t       e;
    exp_t       got;
    logic [2:0] op_exp;
    int         n;
    n = 0;
    @(negedge clk);
    while (!dec_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(dec_ready), 32'(1));
    dec_valid = 1'b1; dec_type = t; funct3 = f3; pc_in = pc; imm = im; rs1_base = rs1;
    e = model(t, f3, pc, im, rs1, cb, kill_at);
    op_exp = e.cmp_op;
    sb.push_back(e);
    @(posedge clk); #1;
    if (junk) begin
      dec_type = 2'b01; pc_in = ~pc; imm = W'(8); rs1_base = ~rs1;
    end else begin
      dec_valid = 1'b0;
    end
    @(negedge clk);
    chk("cmp_op_resolve", 32'(cmp_op), 32'(op_exp));
    cmp_b = cb;
    if (kill_at == 1) kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; cmp_b = ~cb; dec_valid = 1'b0;
    @(negedge clk);
    if (kill_at == 2) begin
      kill = 1'b1;
      #1;
    end
    got = sb.pop_front();
    chk("redirect",  32'(redirect),  32'(got.redirect));
    chk("pc_next",   32'(pc_next),   32'(got.pcn));
    chk("link_we",   32'(link_we),   32'(got.link_we));
    chk("link_d",    32'(link_d),    32'(got.link_d));
    chk("misalign",  32'(misalign),  32'(got.misalign));
    chk("illegal",   32'(illegal),   32'(got.illegal));
    chk("cmp_op_resp", 32'(cmp_op),  32'(3'b111));
    chk("ready_resp", 32'(dec_ready), 32'(got.ready_resp));
    @(posedge clk); #1;
    kill = 1'b0;
    chk("taken_cnt",  32'(taken_cnt), 32'(got.cnt));
    chk("pc_next_held", 32'(pc_next), 32'(got.pcn));
    chk("ready_after", 32'(dec_ready), 32'(!got.flush));
    if (got.flush) begin
      if (kill_at == 3) begin
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("ready_flush_kill", 32'(dec_ready), 32'(1));
      end else if (kill_at == 4) begin
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        exp_pcn = '0;
        chk("rst_redirect",  32'(redirect),  32'(0));
        chk("rst_pc_next",   32'(pc_next),   32'(0));
        chk("rst_taken_cnt", 32'(taken_cnt), 32'(0));
        chk("rst_link",      32'({link_we, link_d}), 32'(0));
        chk("rst_exc",       32'({misalign, illegal}), 32'(0));
        chk("rst_cmp_op",    32'(cmp_op),    32'(3'b111));
        chk("rst_ready",     32'(dec_ready), 32'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("post_rst_quiet", 32'({redirect, link_we, misalign, illegal}), 32'(0));
        end
      end else begin
        @(posedge clk); #1;
        chk("ready_flush2", 32'(dec_ready), 32'(0));
        @(posedge clk); #1;
        chk("ready_flush_end", 32'(dec_ready), 32'(1));
      end
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b1; dec_valid = 1'b0; dec_type = '0; funct3 = '0;
    pc_in = '0; imm = '0; rs1_base = '0; kill = 1'b0; cmp_b = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_ready",    32'(dec_ready), 32'(1));
    chk("reset_cmp_op",   32'(cmp_op),    32'(3'b111));
    chk("reset_pulses",   32'({redirect, link_we, misalign, illegal}), 32'(0));
    chk("reset_pc_next",  32'(pc_next),   32'(0));
    chk("reset_link_d",   32'(link_d),    32'(0));
    chk("reset_cnt",      32'(taken_cnt), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(2'b00, 3'b000, W'('h100), W'('h020), W'(0),     1'b1, 0, 0); // BEQ taken
    issue(2'b00, 3'b110, W'('h100), W'('h020), W'(0),     1'b0, 0, 0); // BLTU not taken
    issue(2'b10, 3'b000, W'('h300), W'('h001), W'('h203), 1'b0, 0, 0); // JALR
    issue(2'b01, 3'b000, W'('h100), W'('h006), W'(0),     1'b0, 0, 0); // JAL misaligned
    issue(2'b00, 3'b010, W'('h100), W'('h020), W'(0),     1'b1, 0, 0); // illegal funct3
    issue(2'b00, 3'b011, W'('h100), W'('h020), W'(0),     1'b1, 0, 0);
    issue(2'b11, 3'b000, W'('h100), W'('h020), W'(0),     1'b1, 0, 0); // reserved type
    issue(2'b00, 3'b000, W'('h200), W'('h040), W'(0),     1'b1, 2, 0); // kill in RESP
    issue(2'b00, 3'b001, W'('h400), W'('hFFC), W'(0),     1'b1, 0, 0); // BNE backward
    issue(2'b00, 3'b100, W'('h400), W'('h010), W'(0),     1'b0, 0, 0); // BLT not taken
    issue(2'b00, 3'b101, W'('hFF0), W'('h010), W'(0),     1'b1, 0, 0); // BGE target wraps
    issue(2'b00, 3'b111, W'('h010), W'('h001), W'(0),     1'b1, 0, 0); // BGEU odd target
    issue(2'b01, 3'b000, W'('hFFC), W'('h008), W'(0),     1'b0, 0, 0); // JAL link wraps
    issue(2'b01, 3'b000, W'('h040), W'('h010), W'(0),     1'b0, 1, 0); // kill in RESOLVE
    issue(2'b00, 3'b000, W'('h500), W'('h100), W'(0),     1'b1, 0, 1); // dec_valid while busy
    issue(2'b00, 3'b000, W'('h600), W'('h004), W'(0),     1'b1, 3, 0); // kill in FLUSH
    issue(2'b00, 3'b000, W'('h700), W'('h004), W'(0),     1'b1, 4, 0); // reset in FLUSH

    guard = 0;
    while (exp_cnt != {W{1'b1}} && guard < 5000) begin
      issue(2'b01, 3'b000, W'(0), W'(4), W'(0), 1'b0, 0, 0);
      guard++;
    end
    issue(2'b01, 3'b000, W'('h010), W'(8), W'(0), 1'b0, 0, 0); // counter wraps to 0
    chk("cnt_wrapped", 32'(taken_cnt), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
